// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared QPSK sample width, symbol codes, demod states and accumulator sizing
package qpsk_pkg;
    localparam int SAMPLE_W = 16;
    localparam logic [1:0] SYM_PP = 2'b00;
    localparam logic [1:0] SYM_PN = 2'b01;
    localparam logic [1:0] SYM_NP = 2'b10;
    localparam logic [1:0] SYM_NN = 2'b11;
    typedef enum logic {IDLE, RUN} demod_state_t;
    function automatic int acc_width(input int sample_w, input int sym_len);
        return 2 * sample_w + $clog2(sym_len);
    endfunction
endpackage

// File: rtl/qpsk_correlator.sv
// qpsk_correlator: one multiply / integrate-and-dump arm of the QPSK demodulator
// Ports: clk, rst (sync, active high); sample, carrier (signed inputs);
//        valid/first/last tags for the sample; corr (dumped correlation) with a one-cycle done strobe.
module qpsk_correlator #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 38
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [SAMPLE_W-1:0] carrier,
    input  logic                       valid,
    input  logic                       first,
    input  logic                       last,
    output logic signed [ACC_W-1:0]    corr,
    output logic                       done
);
    import qpsk_pkg::*;
    localparam int PW = 2 * SAMPLE_W;
    logic signed [PW-1:0] prod;
    logic prod_valid, prod_first, prod_last;
    logic signed [ACC_W-1:0] acc, prod_ext, sum;
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign sum = acc + prod_ext;
    always_ff @(posedge clk) begin
        if (rst) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
            acc        <= '0;
            corr       <= '0;
            done       <= 1'b0;
        end else begin
            prod       <= PW'(sample) * PW'(carrier);
            prod_valid <= valid;
            prod_first <= first;
            prod_last  <= last;
            done       <= prod_valid & prod_last;
            // the first sample of a symbol loads instead of adding, which also discards any partial symbol
            if (prod_valid)
                acc <= prod_first ? prod_ext : sum;
            if (prod_valid & prod_last)
                corr <= sum;
        end
    end
endmodule

// File: rtl/qpsk_demod.sv
// qpsk_demod: coherent QPSK symbol demodulator with integrate-and-dump and a valid/ready output register
// Ports: clk, rst (sync, active high); sin, cos, sample_in qualified by sample_valid, sym_start marks sample 0;
//        rx_sym/i_corr/q_corr held under rx_valid until rx_ready; rx_overrun sticky until reset.
module qpsk_demod #(
    parameter int SAMPLE_W = qpsk_pkg::SAMPLE_W,
    parameter int SYM_LEN  = 64,
    parameter int ACC_W    = qpsk_pkg::acc_width(SAMPLE_W, SYM_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sin,
    input  logic signed [SAMPLE_W-1:0] cos,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sym_start,
    output logic [1:0]                 rx_sym,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic signed [ACC_W-1:0]    i_corr,
    output logic signed [ACC_W-1:0]    q_corr,
    output logic                       rx_overrun
);
    import qpsk_pkg::*;
    localparam int CW = $clog2(SYM_LEN);
    demod_state_t state;
    logic [CW-1:0] cnt, cur;
    logic take, first, last, i_done, q_done, done;
    logic signed [ACC_W-1:0] i_dump, q_dump;
    logic [1:0] sym;
    // in IDLE only a sym_start sample is accepted; it becomes sample 0 and enters RUN
    assign take  = sample_valid & ((state == RUN) | sym_start);
    assign cur   = sym_start ? '0 : cnt;
    assign first = cur == '0;
    assign last  = cur == CW'(SYM_LEN - 1);
    assign done  = i_done & q_done;
    assign sym   = i_dump[ACC_W-1] ? (q_dump[ACC_W-1] ? SYM_NN : SYM_PN)
                                   : (q_dump[ACC_W-1] ? SYM_NP : SYM_PP);

    qpsk_correlator #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_i (
        .clk(clk), .rst(rst), .sample(sample_in), .carrier(sin),
        .valid(take), .first(first), .last(last), .corr(i_dump), .done(i_done)
    );
    qpsk_correlator #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_q (
        .clk(clk), .rst(rst), .sample(sample_in), .carrier(cos),
        .valid(take), .first(first), .last(last), .corr(q_dump), .done(q_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rx_sym     <= SYM_PP;
            rx_valid   <= 1'b0;
            i_corr     <= '0;
            q_corr     <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (take) begin
                state <= RUN;
                cnt   <= last ? '0 : cur + 1'b1;
            end
            if (done) begin
                rx_sym   <= sym;
                rx_valid <= 1'b1;
                i_corr   <= i_dump;
                q_corr   <= q_dump;
                if (rx_valid & ~rx_ready)
                    rx_overrun <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_qpsk_demod.sv
// tb_qpsk_demod: table-driven, directed and randomized checks of qpsk_demod against a symbol-level model
module tb_qpsk_demod;
    import qpsk_pkg::*;
    localparam int SL = 8;
    localparam int AW = qpsk_pkg::acc_width(16, SL);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] sin = '0, cos = '0, sample_in = '0;
    logic sample_valid = 1'b0, sym_start = 1'b0, rx_ready = 1'b0;
    logic [1:0] rx_sym;
    logic rx_valid, rx_overrun;
    logic [AW-1:0] i_corr, q_corr;

    qpsk_demod #(.SAMPLE_W(16), .SYM_LEN(SL)) dut (
        .clk(clk), .rst(rst), .sin(sin), .cos(cos), .sample_in(sample_in),
        .sample_valid(sample_valid), .sym_start(sym_start), .rx_sym(rx_sym),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .i_corr(i_corr), .q_corr(q_corr),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0, vcount = 0;
    int sp[4] = '{100, 100, -100, -100};
    int cp[4] = '{100, -100, -100, 100};

    typedef struct {
        int a;
        int b;
        longint ei;
        longint eq;
        logic [1:0] sym;
    } vec_t;
    vec_t tbl[4];

    // symbol-level model: sums of products per symbol, a 2-edge delay, and the holding register
    bit m_run, c0_v, c1_v, e_v, e_ovr;
    int m_idx;
    longint m_i, m_q, c0_i, c0_q, c1_i, c1_q, e_i, e_q;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit v, input bit st, input bit rdy,
                         input int smp, input int s, input int c);
        if (r) begin
            m_run = 0; m_idx = 0; m_i = 0; m_q = 0;
            c0_v = 0; c1_v = 0; e_v = 0; e_ovr = 0; e_i = 0; e_q = 0;
            return;
        end
        if (c1_v) begin
            if (e_v && !rdy) e_ovr = 1;
            e_v = 1; e_i = c1_i; e_q = c1_q;
        end else if (rdy) begin
            e_v = 0;
        end
        c1_v = c0_v; c1_i = c0_i; c1_q = c0_q; c0_v = 0;
        if (v && (m_run || st)) begin
            m_run = 1;
            if (st) m_idx = 0;
            if (m_idx == 0) begin m_i = 0; m_q = 0; end
            m_i += longint'(smp) * longint'(s);
            m_q += longint'(smp) * longint'(c);
            m_idx++;
            if (m_idx == SL) begin
                c0_v = 1; c0_i = m_i; c0_q = m_q; m_idx = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit st, input bit rdy,
                        input int smp, input int s, input int c);
        @(negedge clk);
        rst = r; sample_valid = v; sym_start = st; rx_ready = rdy;
        sample_in = 16'(smp); sin = 16'(s); cos = 16'(c);
        model(r, v, st, rdy, smp, s, c);
        @(posedge clk);
        #1;
        if (rx_valid) vcount++;
        check("model_rx_valid", longint'(rx_valid), longint'(e_v));
        check("model_rx_overrun", longint'(rx_overrun), longint'(e_ovr));
        check("model_i_corr", longint'($signed(i_corr)), e_i);
        check("model_q_corr", longint'($signed(q_corr)), e_q);
        check("model_rx_sym", longint'(rx_sym), 2 * longint'(e_q < 0) + longint'(e_i < 0));
    endtask

    task automatic send(input int a, input int b, input int k, input bit st, input bit rdy);
        step(0, 1, st, rdy, a * sp[k % 4] + b * cp[k % 4], sp[k % 4], cp[k % 4]);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0, 0, 0);
    endtask

    function automatic int r16();
        logic signed [15:0] x;
        x = 16'($urandom);
        return int'(x);
    endfunction

    initial begin
        int vs;
        tbl[0] = '{1, 1, 80000, 80000, SYM_PP};
        tbl[1] = '{-1, 1, -80000, 80000, SYM_PN};
        tbl[2] = '{1, -1, 80000, -80000, SYM_NP};
        tbl[3] = '{-1, -1, -80000, -80000, SYM_NN};

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 123, 45, 67);
        check("reset_rx_valid", longint'(rx_valid), 0);
        check("reset_i_corr", longint'(i_corr), 0);
        check("reset_q_corr", longint'(q_corr), 0);
        check("reset_rx_sym", longint'(rx_sym), 0);
        check("reset_rx_overrun", longint'(rx_overrun), 0);
        idle(2, 1);

        // clean symbols, one-cycle rx_valid pulse two edges after the last sample
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < SL; k++) send(tbl[t].a, tbl[t].b, k, k == 0, 1);
            check("tbl_valid_at_last", longint'(rx_valid), 0);
            idle(1, 1);
            check("tbl_valid_plus1", longint'(rx_valid), 0);
            idle(1, 1);
            check("tbl_valid_plus2", longint'(rx_valid), 1);
            check("tbl_i_corr", longint'($signed(i_corr)), tbl[t].ei);
            check("tbl_q_corr", longint'($signed(q_corr)), tbl[t].eq);
            check("tbl_rx_sym", longint'(rx_sym), longint'(tbl[t].sym));
            idle(1, 1);
            check("tbl_valid_pulse", longint'(rx_valid), 0);
        end

        // back-to-back symbols without ready: overwrite and overrun
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < SL; k++) send(tbl[t].a, tbl[t].b, k, k == 0, 0);
        idle(3, 0);
        check("ovr_rx_overrun", longint'(rx_overrun), 1);
        check("ovr_rx_valid", longint'(rx_valid), 1);
        check("ovr_rx_sym", longint'(rx_sym), longint'(SYM_PN));
        check("ovr_i_corr", longint'($signed(i_corr)), -80000);
        idle(1, 1);
        check("ovr_accept_valid", longint'(rx_valid), 0);
        check("ovr_sticky", longint'(rx_overrun), 1);
        step(1, 0, 0, 1, 0, 0, 0);
        check("ovr_cleared_by_rst", longint'(rx_overrun), 0);
        idle(1, 1);

        // restart mid-symbol discards the partial symbol
        vs = vcount;
        for (int k = 0; k < 5; k++) send(1, 1, k, k == 0, 1);
        for (int k = 0; k < SL; k++) send(-1, -1, k, k == 0, 1);
        check("restart_no_partial", longint'(vcount - vs), 0);
        idle(2, 1);
        check("restart_valid", longint'(rx_valid), 1);
        check("restart_rx_sym", longint'(rx_sym), longint'(SYM_NN));
        idle(1, 1);

        // sample_valid low every other cycle
        for (int k = 0; k < SL; k++) begin
            idle(1, 1);
            send(1, 1, k, k == 0, 1);
        end
        idle(2, 1);
        check("gap_valid", longint'(rx_valid), 1);
        check("gap_i_corr", longint'($signed(i_corr)), 80000);
        check("gap_q_corr", longint'($signed(q_corr)), 80000);
        check("gap_rx_sym", longint'(rx_sym), longint'(SYM_PP));
        idle(1, 1);

        // reset two samples before the end of a symbol
        for (int k = 0; k < 6; k++) send(1, -1, k, k == 0, 1);
        vs = vcount;
        step(1, 0, 0, 1, 0, 0, 0);
        for (int k = 6; k < SL; k++) send(1, -1, k, 0, 1);
        idle(4, 1);
        check("rst_mid_no_valid", longint'(vcount - vs), 0);
        check("rst_mid_i_corr", longint'(i_corr), 0);
        check("rst_mid_q_corr", longint'(q_corr), 0);
        check("rst_mid_rx_sym", longint'(rx_sym), 0);
        for (int k = 0; k < SL; k++) send(1, -1, k, 0, 1);
        idle(3, 1);
        check("rst_idle_ignores", longint'(vcount - vs), 0);
        for (int k = 0; k < SL; k++) send(1, -1, k, k == 0, 1);
        idle(2, 1);
        check("rst_resume_valid", longint'(rx_valid), 1);
        check("rst_resume_rx_sym", longint'(rx_sym), longint'(SYM_NP));
        idle(1, 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++)
            step($urandom % 600 == 0, $urandom % 4 != 0, $urandom % 24 == 0,
                 $urandom % 3 != 0, r16(), r16(), r16());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/qpsk_demod.md
# qpsk_demod

Coherent QPSK symbol demodulator: the receive-side counterpart of the QPSK modulator. It multiplies each received 16-bit sample by the local sin and cos references from the same DDS that feeds the modulator, integrates both products over one symbol period (integrate-and-dump), and decides the 2-bit symbol from the signs of the two correlations. Decided symbols go out through a valid/ready holding register to the downstream symbol consumer.

## Interface

- `SAMPLE_W`, 16, width of the samples and references (signed two's complement).
- `SYM_LEN`, 64, samples per symbol; ≥ 2.
- `ACC_W`, 2*SAMPLE_W + $clog2(SYM_LEN), accumulator width; this width cannot overflow.

- `clk`  in  1  system clock; one clock only.
- `rst`  in  1  synchronous, active-high reset.
- `sin`  in  SAMPLE_W  sine reference, signed, aligned with `sample_in`.
- `cos`  in  SAMPLE_W  cosine reference, signed, aligned with `sample_in`.
- `sample_in`  in  SAMPLE_W  received sample, signed.
- `sample_valid`  in  1  qualifies `sample_in`, `sin` and `cos`.
- `sym_start`  in  1  marks the qualified sample as sample 0 of a symbol; ignored without `sample_valid`.
- `rx_sym`  out  2  decided symbol; bit0 = sin arm, bit1 = cos arm.
- `rx_valid`  out  1  `rx_sym`, `i_corr` and `q_corr` are valid.
- `rx_ready`  in  1  consumer accepts the symbol.
- `i_corr`  out  ACC_W  final sin-arm correlation for the held symbol.
- `q_corr`  out  ACC_W  final cos-arm correlation for the held symbol.
- `rx_overrun`  out  1  sticky; a held symbol was overwritten before it was accepted.

## Operation

- States: IDLE and RUN. Reset enters IDLE. IDLE → RUN on `sample_valid & sym_start`. There is no exit from RUN except reset.
- Stage 1 registers the signed products `sample_in*sin` and `sample_in*cos` (2*SAMPLE_W bits each), plus a valid bit and a first/last tag.
- Stage 2 accumulates the sign-extended products into `i_acc` and `q_acc` (ACC_W bits).
  - A sample tagged first loads the accumulator with its product; it does not add.
  - A sample tagged last dumps the accumulator value plus its product into the output register.
- Sample counter `cnt` (0..SYM_LEN-1) advances only on qualified samples in RUN.
  - `sym_start` forces `cnt` = 0 for that sample.
  - `cnt` = SYM_LEN-1 tags the sample last, and the next sample becomes sample 0 automatically (wrap-around).
- `sym_start` in RUN mid-symbol discards the partial symbol: nothing is emitted and the accumulation restarts from this sample.
- Decision rule: bit = 1 when the correlation is negative, 0 when it is ≥ 0 (zero decides 0).
  - `rx_sym[0]` = sign of `i_acc`; `rx_sym[1]` = sign of `q_acc`.
  - Matches modulator TX bit n = 1 meaning the corresponding reference is negated.
- Output register handshake:
  - A dump loads the register and sets `rx_valid`.
  - `rx_valid & rx_ready` clears `rx_valid`.
  - A dump while `rx_valid` is set and `rx_ready` is low overwrites the register, keeps `rx_valid` high and sets `rx_overrun`.
  - A dump in the same cycle as an accept loads the new symbol and keeps `rx_valid` high; no overrun is flagged.
- `sample_valid` gaps are legal and may be arbitrarily long. The pipeline carries valid bits and does not stall.

## Timing

- Reset values: `rx_sym` = 0, `rx_valid` = 0, `i_corr` = 0, `q_corr` = 0, `rx_overrun` = 0, `cnt` = 0, accumulators = 0, state IDLE.
- Reset asserted mid-symbol or while in flight discards all partial and pending symbols; no `rx_valid` follows.
- Latency: `rx_valid` rises on the 2nd rising edge after the edge that samples the last qualified sample of a symbol. Example: last sample captured at edge N, `rx_valid` high after edge N+2.
- Throughput: one sample per clock. `rx_valid` is never forced low by the block itself.
- `rx_overrun` clears only on `rst`.

## Structure

- Shared package `qpsk_pkg`:
  - `SAMPLE_W` default;
  - symbol constants `SYM_PP` = 2'b00, `SYM_PN` = 2'b01, `SYM_NP` = 2'b10, `SYM_NN` = 2'b11, shared with the modulator;
  - function for ACC_W.
- Sub-module `qpsk_correlator`: one multiply-accumulate arm with first/last tags and dump output. Instantiate it twice, once for sin and once for cos.
- Counter, state, decision logic and the output register stay in the top level.

## Test plan

Bench uses SYM_LEN = 8. Reference pattern, repeating every 4 samples: sin = +100, +100, −100, −100; cos = +100, −100, −100, +100. Tests 1–3 and 5 use it.

1. `sample_in` = sin + cos for 8 samples, `sym_start` on the first, `rx_ready` = 1 → `i_corr` = 80000, `q_corr` = 80000, `rx_sym` = 00, `rx_valid` a 1-cycle pulse two edges after the last sample.
2. `sample_in` = −sin + cos → `i_corr` = −80000, `q_corr` = 80000, `rx_sym` = 01. Repeat with sin − cos → 10, and −sin − cos → 11.
3. Back-to-back symbols with `rx_ready` = 0 → first symbol held. The second dump overwrites it, sets `rx_overrun` = 1, and `rx_valid` stays high.
4. `sym_start` re-asserted at sample 5 of a symbol → no output for the partial symbol. The next `rx_valid` appears 8 samples after the re-start.
5. Run symbol 1's stimulus with `sample_valid` low every other cycle → results identical to test 1.
6. `rst` pulsed 2 samples before a symbol's last sample → no `rx_valid`, all outputs 0, state IDLE until the next `sym_start`.
